// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with an optional accumulator operand and an
// in-order result FIFO, valid/ready handshakes on both sides.
module logic_unit_pipe #(
    parameter int unsigned           WIDTH    = 4,
    parameter int unsigned           DEPTH    = 4,
    parameter logic [WIDTH-1:0]      ACC_INIT = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 op,
    input  logic                       acc_en,
    input  logic                       acc_clr,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           y,
    output logic                       y_and,
    output logic                       y_or,
    output logic                       y_xor,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           acc
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOTA = 3'b110,
        OP_PASS = 3'b111
    } op_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] r;
    logic             push;
    logic             pop;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // A same-cycle clear is visible to an accumulating operand read.
    assign opb = acc_en ? (acc_clr ? ACC_INIT : acc) : b;

    always_comb begin
        r = '0;
        unique case (op_t'(op))
            OP_AND:  r = a & opb;
            OP_OR:   r = a | opb;
            OP_XOR:  r = a ^ opb;
            OP_NAND: r = ~(a & opb);
            OP_NOR:  r = ~(a | opb);
            OP_XNOR: r = ~(a ^ opb);
            OP_NOTA: r = ~a;
            OP_PASS: r = a;
            default: r = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= r;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= ACC_INIT;
        end else if (push && acc_en) begin
            acc <= r;
        end else if (acc_clr) begin
            acc <= ACC_INIT;
        end
    end

    // Head storage is not reset, so every head-derived output is gated by out_valid.
    assign y     = out_valid ? mem[rd_ptr] : '0;
    assign y_and = out_valid & (&y);
    assign y_or  = out_valid & (|y);
    assign y_xor = out_valid & (^y);

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe at WIDTH=4, DEPTH=4, ACC_INIT=0.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic       acc_en;
    logic       acc_clr;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] y;
    logic       y_and;
    logic       y_or;
    logic       y_xor;
    logic [2:0] count;
    logic [3:0] acc;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [3:0] exp1 [8];
    logic [3:0] exp3 [4];

    logic_unit_pipe #(
        .WIDTH    (4),
        .DEPTH    (4),
        .ACC_INIT (4'b0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_and     (y_and),
        .y_or      (y_or),
        .y_xor     (y_xor),
        .count     (count),
        .acc       (acc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle on the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [2:0] o, input logic ae, input logic [3:0] av, input logic [3:0] bv);
        in_valid = 1'b1;
        op       = o;
        acc_en   = ae;
        a        = av;
        b        = bv;
    endtask

    initial begin
        exp1 = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0011, 4'b1100};
        exp3 = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

        rst = 1'b1; in_valid = 1'b0; op = '0; acc_en = 1'b0; acc_clr = 1'b0;
        a = '0; b = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_count",    32'(count),     32'd0);
        check("rst_valid",    32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready),  32'd1);
        check("rst_y",        32'(y),         32'd0);
        check("rst_acc",      32'(acc),       32'd0);
        rst = 1'b0;
        @(negedge clk);

        // All eight ops, streaming with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(3'(i), 1'b0, 4'b1100, 4'b1010);
            cyc();
            check("op_y",     32'(y),         32'(exp1[i]));
            check("op_valid", 32'(out_valid), 32'd1);
            check("op_count", 32'(count),     32'd1);
        end
        in_valid = 1'b0;
        cyc();
        check("op_drain", 32'(count), 32'd0);

        // Fill with the consumer stalled, then hold a fifth operand against full.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(3'(i), 1'b0, 4'b1100, 4'b1010);
            cyc();
        end
        check("full_count", 32'(count),    32'd4);
        check("full_ready", 32'(in_ready), 32'd0);
        push(3'b100, 1'b0, 4'b1100, 4'b1010);
        cyc();
        cyc();
        check("held_count", 32'(count), 32'd4);
        check("held_head",  32'(y),     32'b1000);
        out_ready = 1'b1;
        cyc();
        check("pop_full_count", 32'(count), 32'd3);
        check("pop_full_y",     32'(y),     32'b1110);
        cyc();
        in_valid = 1'b0;
        check("q2_y2",     32'(y),     32'b0110);
        check("q2_count2", 32'(count), 32'd3);
        cyc();
        check("q2_y3", 32'(y), 32'b0111);
        cyc();
        check("q2_y4", 32'(y), 32'b0001);
        cyc();
        check("q2_empty", 32'(count),     32'd0);
        check("q2_evld",  32'(out_valid), 32'd0);

        // Accumulate via XOR; each transfer sees the prior result.
        for (int i = 0; i < 4; i++) begin
            push(3'b010, 1'b1, 4'(1 << i), 4'b0000);
            cyc();
            check("acc_y",   32'(y),   32'(exp3[i]));
            check("acc_val", 32'(acc), 32'(exp3[i]));
            if (i == 2) begin
                check("red_and", 32'(y_and), 32'd0);
                check("red_or",  32'(y_or),  32'd1);
                check("red_xor", 32'(y_xor), 32'd1);
            end
        end

        // A non-accumulating transfer leaves acc alone.
        push(3'b111, 1'b0, 4'b0101, 4'b0000);
        cyc();
        check("noacc_y",   32'(y),   32'b0101);
        check("noacc_acc", 32'(acc), 32'b1111);

        // Clear coincident with an accumulating transfer: clear precedes read.
        acc_clr = 1'b1;
        push(3'b001, 1'b1, 4'b0011, 4'b0000);
        cyc();
        check("clr_y",   32'(y),   32'b0011);
        check("clr_acc", 32'(acc), 32'b0011);
        in_valid = 1'b0;
        acc_en   = 1'b0;
        cyc();
        check("clr_only_acc", 32'(acc),   32'b0000);
        check("clr_empty",    32'(count), 32'd0);
        acc_clr = 1'b0;

        // Simultaneous push and pop at count=2.
        out_ready = 1'b0;
        push(3'b111, 1'b0, 4'b0001, 4'b0000); cyc();
        push(3'b111, 1'b0, 4'b0010, 4'b0000); cyc();
        check("pp_pre", 32'(count), 32'd2);
        push(3'b111, 1'b0, 4'b0011, 4'b0000);
        out_ready = 1'b1;
        cyc();
        check("pp_count", 32'(count), 32'd2);
        check("pp_head",  32'(y),     32'b0010);
        out_ready = 1'b0;
        push(3'b111, 1'b0, 4'b0100, 4'b0000); cyc();
        push(3'b111, 1'b0, 4'b0101, 4'b0000); cyc();
        check("pf_pre", 32'(count), 32'd4);
        push(3'b111, 1'b0, 4'b0110, 4'b0000);
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("pf_count", 32'(count), 32'd3);
        check("pf_y0",    32'(y),     32'b0011);
        cyc();
        check("pf_y1", 32'(y), 32'b0100);
        cyc();
        check("pf_y2", 32'(y), 32'b0101);
        cyc();
        check("pf_empty", 32'(count), 32'd0);

        // Asynchronous reset mid-stream, between clock edges.
        out_ready = 1'b0;
        push(3'b001, 1'b1, 4'b1010, 4'b0000); cyc();
        push(3'b111, 1'b0, 4'b1011, 4'b0000); cyc();
        push(3'b111, 1'b0, 4'b1101, 4'b0000); cyc();
        in_valid = 1'b0;
        check("ar_pre_count", 32'(count), 32'd3);
        check("ar_pre_acc",   32'(acc),   32'b1010);
        #1 rst = 1'b1;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_count", 32'(count),     32'd0);
        check("ar_y",     32'(y),         32'd0);
        check("ar_acc",   32'(acc),       32'd0);
        check("ar_ready", 32'(in_ready),  32'd1);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ar_post_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        push(3'b111, 1'b0, 4'b1111, 4'b0000);
        cyc();
        in_valid = 1'b0;
        check("ar_new_y",     32'(y),     32'b1111);
        check("ar_new_count", 32'(count), 32'd1);
        cyc();
        check("ar_final", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
